// File: rtl/midi_msg_parser.sv
// Assembles MIDI channel/system-common messages from received bytes; msg_valid/rt_valid pulse 1 cycle after the final byte strobe.
// No backpressure: input is strobe-driven and every byte is consumed in its strobe cycle.
module midi_msg_parser #(
    parameter bit         OMNI      = 1'b1,
    parameter logic [3:0] CHANNEL   = 4'd0,
    parameter bit         V0_AS_OFF = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] data_rx,
    input  logic       is_command,
    input  logic       new_byte_strobe,
    output logic       msg_valid,
    output logic [7:0] msg_status,
    output logic [6:0] msg_d1,
    output logic [6:0] msg_d2,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

    state_t     state_q, state_d;
    logic [7:0] st_q, st_d;
    logic       chan_q, chan_d;
    logic [6:0] d1_q, d1_d;

    logic       need1;
    logic       msg_done;
    logic       emit;
    logic [7:0] emit_st;
    logic [6:0] emit_d1, emit_d2;
    logic       drop;
    logic       rt_hit;
    logic       filtered;
    logic [7:0] out_st;

    assign need1 = (st_q[7:4] == 4'hC) || (st_q[7:4] == 4'hD) ||
                   (st_q == 8'hF1) || (st_q == 8'hF3);

    always_comb begin
        state_d  = state_q;
        st_d     = st_q;
        chan_d   = chan_q;
        d1_d     = d1_q;
        msg_done = 1'b0;
        emit     = 1'b0;
        emit_st  = st_q;
        emit_d1  = 7'd0;
        emit_d2  = 7'd0;
        drop     = 1'b0;
        rt_hit   = 1'b0;
        if (new_byte_strobe) begin
            if (is_command) begin
                if (data_rx >= 8'hF8) begin
                    rt_hit = 1'b1;
                end else if (data_rx < 8'hF0) begin
                    st_d    = data_rx;
                    chan_d  = 1'b1;
                    state_d = WAIT_D1;
                end else begin
                    case (data_rx)
                        8'hF0: begin
                            chan_d  = 1'b0;
                            state_d = SYSEX;
                        end
                        8'hF7: state_d = IDLE;
                        8'hF1, 8'hF2, 8'hF3: begin
                            st_d    = data_rx;
                            chan_d  = 1'b0;
                            state_d = WAIT_D1;
                        end
                        8'hF6: begin
                            chan_d  = 1'b0;
                            emit    = 1'b1;
                            emit_st = 8'hF6;
                            state_d = IDLE;
                        end
                        default: begin
                            chan_d  = 1'b0;
                            state_d = IDLE;
                        end
                    endcase
                end
            end else begin
                case (state_q)
                    SYSEX: ;
                    WAIT_D2: begin
                        msg_done = 1'b1;
                        emit_d1  = d1_q;
                        emit_d2  = data_rx[6:0];
                    end
                    default: begin
                        // IDLE with a live channel running status behaves like WAIT_D1
                        if (state_q == IDLE && !chan_q) begin
                            drop = 1'b1;
                        end else if (need1) begin
                            msg_done = 1'b1;
                            emit_d1  = data_rx[6:0];
                        end else begin
                            d1_d    = data_rx[6:0];
                            state_d = WAIT_D2;
                        end
                    end
                endcase
            end
        end
        if (msg_done) begin
            emit = 1'b1;
            if (chan_q) begin
                state_d = WAIT_D1;
            end else begin
                state_d = IDLE;
                st_d    = 8'h00;
            end
        end
    end

    assign filtered = !OMNI && (emit_st[7:4] != 4'hF) && (emit_st[3:0] != CHANNEL);
    assign out_st   = (V0_AS_OFF && emit_st[7:4] == 4'h9 && emit_d2 == 7'd0) ?
                      {4'h8, emit_st[3:0]} : emit_st;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            st_q       <= 8'h00;
            chan_q     <= 1'b0;
            d1_q       <= 7'd0;
            msg_valid  <= 1'b0;
            msg_status <= 8'h00;
            msg_d1     <= 7'd0;
            msg_d2     <= 7'd0;
            rt_valid   <= 1'b0;
            rt_byte    <= 8'h00;
            drop_cnt   <= 8'h00;
        end else begin
            state_q   <= state_d;
            st_q      <= st_d;
            chan_q    <= chan_d;
            d1_q      <= d1_d;
            msg_valid <= emit && !filtered;
            if (emit && !filtered) begin
                msg_status <= out_st;
                msg_d1     <= emit_d1;
                msg_d2     <= emit_d2;
            end
            rt_valid <= rt_hit;
            if (rt_hit) begin
                rt_byte <= data_rx;
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Drives one byte stream into an omni parser and a channel-2 filtered parser, checking both against a message-level model.
module tb_midi_msg_parser;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] data_rx;
    logic       is_command;
    logic       new_byte_strobe;

    logic [1:0] mv, rv;
    logic [7:0] ms [2];
    logic [7:0] rb [2];
    logic [7:0] dc [2];
    logic [6:0] d1 [2];
    logic [6:0] d2 [2];

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    midi_msg_parser u_omni (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_rx(data_rx),
        .is_command(is_command), .new_byte_strobe(new_byte_strobe),
        .msg_valid(mv[0]), .msg_status(ms[0]), .msg_d1(d1[0]), .msg_d2(d2[0]),
        .rt_valid(rv[0]), .rt_byte(rb[0]), .drop_cnt(dc[0])
    );

    midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd2), .V0_AS_OFF(1'b1)) u_filt (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_rx(data_rx),
        .is_command(is_command), .new_byte_strobe(new_byte_strobe),
        .msg_valid(mv[1]), .msg_status(ms[1]), .msg_d1(d1[1]), .msg_d2(d2[1]),
        .rt_valid(rv[1]), .rt_byte(rb[1]), .drop_cnt(dc[1])
    );

    // Model: current status (0 = none), whether it is a channel status, collected data bytes
    logic [7:0] m_cur  [2];
    bit         m_chan [2];
    bit         m_sx   [2];
    int         m_n    [2];
    logic [6:0] m_d    [2][2];
    bit         e_mv   [2];
    bit         e_rv   [2];
    logic [7:0] e_st   [2];
    logic [7:0] e_rb   [2];
    logic [7:0] e_dc   [2];
    logic [6:0] e_d1   [2];
    logic [6:0] e_d2   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int need_of(input logic [7:0] s);
        if (s[7:4] == 4'hC || s[7:4] == 4'hD || s == 8'hF1 || s == 8'hF3) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cur[k] = 8'h00; m_chan[k] = 0; m_sx[k] = 0; m_n[k] = 0;
            e_mv[k] = 0; e_rv[k] = 0; e_st[k] = 8'h00; e_rb[k] = 8'h00;
            e_dc[k] = 8'h00; e_d1[k] = 7'd0; e_d2[k] = 7'd0;
        end
    endtask

    task automatic model_emit(input int k, input logic [7:0] s, input logic [6:0] a, input logic [6:0] b);
        logic [7:0] st;
        st = s;
        if (s[7:4] == 4'h9 && b == 7'd0) st = {4'h8, s[3:0]};
        if (k == 1 && s < 8'hF0 && s[3:0] != 4'd2) return;
        e_mv[k] = 1; e_st[k] = st; e_d1[k] = a; e_d2[k] = b;
    endtask

    task automatic model_byte(input int k, input logic [7:0] b, input bit cmd);
        if (cmd) begin
            if (b >= 8'hF8) begin
                e_rv[k] = 1; e_rb[k] = b;
            end else begin
                m_n[k] = 0; m_sx[k] = 0;
                if (b < 8'hF0) begin
                    m_cur[k] = b; m_chan[k] = 1;
                end else if (b == 8'hF0) begin
                    m_cur[k] = 0; m_chan[k] = 0; m_sx[k] = 1;
                end else if (b == 8'hF7) begin
                    if (!m_chan[k]) m_cur[k] = 0;
                end else if (b >= 8'hF1 && b <= 8'hF3) begin
                    m_cur[k] = b; m_chan[k] = 0;
                end else if (b == 8'hF6) begin
                    m_cur[k] = 0; m_chan[k] = 0;
                    model_emit(k, 8'hF6, 7'd0, 7'd0);
                end else begin
                    m_cur[k] = 0; m_chan[k] = 0;
                end
            end
        end else if (m_sx[k]) begin
        end else if (m_cur[k] == 8'h00) begin
            if (e_dc[k] != 8'hFF) e_dc[k] = e_dc[k] + 8'd1;
        end else begin
            m_d[k][m_n[k]] = b[6:0];
            m_n[k]++;
            if (m_n[k] == need_of(m_cur[k])) begin
                model_emit(k, m_cur[k], m_d[k][0], (m_n[k] == 2) ? m_d[k][1] : 7'd0);
                m_n[k] = 0;
                if (!m_chan[k]) m_cur[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("msg_valid%0d", k), mv[k], e_mv[k]);
            check($sformatf("msg_status%0d", k), ms[k], e_st[k]);
            check($sformatf("msg_d1_%0d", k), d1[k], e_d1[k]);
            check($sformatf("msg_d2_%0d", k), d2[k], e_d2[k]);
            check($sformatf("rt_valid%0d", k), rv[k], e_rv[k]);
            check($sformatf("rt_byte%0d", k), rb[k], e_rb[k]);
            check($sformatf("drop_cnt%0d", k), dc[k], e_dc[k]);
            e_mv[k] = 0; e_rv[k] = 0;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit cmd, input int gap);
        data_rx = b; is_command = cmd; new_byte_strobe = 1'b1;
        for (int k = 0; k < 2; k++) model_byte(k, b, cmd);
        @(posedge sys_clk); #1;
        new_byte_strobe = 1'b0;
        check_all();
        for (int i = 0; i < gap; i++) begin
            @(posedge sys_clk); #1;
            check_all();
        end
    endtask

    task automatic c(input logic [7:0] b);
        send(b, 1'b1, $urandom_range(1, 3));
    endtask

    task automatic d(input logic [7:0] b);
        send(b, 1'b0, $urandom_range(1, 3));
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        logic [7:0] b;
        int r;
        sys_rst = 1'b1; data_rx = 8'h00; is_command = 1'b0; new_byte_strobe = 1'b0;
        model_reset();
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        check_all();

        c(8'h93); d(8'h3C); d(8'h64);
        check("noteon_status", ms[0], 8'h93);

        do_reset();
        c(8'h90); d(8'h40); d(8'h7F); d(8'h41); d(8'h00);
        check("v0_off_status", ms[0], 8'h80);
        check("v0_off_d1", d1[0], 7'h41);

        c(8'hB0); d(8'h07); c(8'hF8); d(8'h64);
        check("rt_interleave_byte", rb[0], 8'hF8);
        check("rt_interleave_d2", d2[0], 7'h64);

        do_reset();
        c(8'hC5); d(8'h0A);
        check("pc_d2_zero", d2[0], 7'h00);
        c(8'hF0); d(8'h01); d(8'h02); c(8'hF7); d(8'h05);
        check("sysex_drop", dc[0], 8'd1);
        check("sysex_status_held", ms[0], 8'hC5);

        do_reset();
        c(8'h91); d(8'h30); d(8'h40); c(8'h92); d(8'h30); d(8'h40);
        check("filter_status", ms[1], 8'h92);

        c(8'hF2); d(8'h11); d(8'h22); d(8'h33);
        c(8'hF6); c(8'hF3); d(8'h05); c(8'hF4); d(8'h06);

        c(8'h90); d(8'h40);
        do_reset();
        d(8'h50);
        check("reset_mid_drop", dc[0], 8'd1);

        for (int i = 0; i < 300; i++) send(8'h2A, 1'b0, 1);
        check("drop_saturate", dc[0], 8'hFF);

        do_reset();
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 99);
            if (r == 0) begin
                do_reset();
            end else if (r < 55) begin
                d(8'($urandom_range(0, 127)));
            end else if (r < 72) begin
                b = 8'($urandom_range(8'h80, 8'hEF));
                if ($urandom_range(0, 1) == 1) b = {b[7:4], 4'h2};
                c(b);
            end else if (r < 84) begin
                c(8'($urandom_range(8'hF8, 8'hFF)));
            end else begin
                c(8'($urandom_range(8'hF0, 8'hF7)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Consumes the byte stream from the single-byte MIDI receiver (data byte, command flag, one-cycle new-byte strobe) and assembles complete channel and system-common messages.
- Implements running status, realtime pass-through, SysEx discard and an optional channel filter.
- Emits one-cycle message strobes with held fields to downstream voice/LED logic.
- Sits directly downstream of single_midi_in, in the sys_clk (48 MHz HFOSC) domain.

Parameters:
- OMNI, 1: 1 = accept all channels; 0 = accept only channel CHANNEL.
- CHANNEL, 0: 4-bit channel number used when OMNI = 0.
- V0_AS_OFF, 1: 1 = Note On (0x9n) with velocity 0 is reported as Note Off (0x8n, same channel).

Ports:
- sys_clk  in  1  system clock, 48 MHz.
- sys_rst  in  1  reset; synchronous to sys_clk, active-high.
- data_rx  in  8  byte from the receiver; valid when new_byte_strobe = 1.
- is_command  in  1  byte is a status byte; authoritative, data_rx[7] is not re-checked.
- new_byte_strobe  in  1  one-cycle pulse per received byte.
- msg_valid  out  1  one-cycle pulse: a complete message is on msg_* outputs.
- msg_status  out  8  status byte of the message (running status applied).
- msg_d1  out  7  first data byte; 0 if the message has none.
- msg_d2  out  7  second data byte; 0 if the message has fewer than two.
- rt_valid  out  1  one-cycle pulse: realtime byte received.
- rt_byte  out  8  realtime byte (0xF8-0xFF); held until the next realtime byte.
- drop_cnt  out  8  saturating count of discarded data bytes.

Behaviour:
- Clock and reset: one clock, sys_clk. sys_rst is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; running status cleared. A reset mid-message discards the partial message, with no msg_valid.
- Byte classes, evaluated only on new_byte_strobe:
  - Realtime F8-FF: rt_byte <= byte and rt_valid = 1 on the next cycle. State, running status and partial data are untouched, even mid-message or mid-SysEx.
  - Channel status 80-EF: running status <= byte; need = 1 for Cn/Dn, 2 otherwise. Go to WAIT_D1 and discard any partial message.
  - F0: clear running status; go to SYSEX.
  - F7: go to IDLE; no message is emitted.
  - F1, F3: need = 1. F2: need = 2. Running status is cleared; the status is held as a one-shot.
  - F6: emit immediately, d1 = d2 = 0; clear running status.
  - F4, F5: clear running status; go to IDLE.
  - Data byte: handled per state below.
- States:
  - IDLE: data with a valid running status behaves as in WAIT_D1. Data without one goes to drop_cnt and the state stays IDLE.
  - WAIT_D1: latch d1. If need = 1, emit. Otherwise go to WAIT_D2.
  - WAIT_D2: latch d2 and emit.
  - After emit: with a channel running status, go to WAIT_D1. For system common, clear the one-shot and go to IDLE.
  - SYSEX: all data bytes are ignored; they are not counted in drop_cnt.
- Emit timing:
  - msg_valid is asserted the cycle after the strobe of the final byte, for exactly 1 cycle.
  - msg_status, msg_d1 and msg_d2 update in that same cycle and hold until the next emit.
- Filter:
  - Applies only when OMNI = 0, and only to channel messages whose status[3:0] != CHANNEL.
  - Such messages are parsed normally, but msg_valid is suppressed and the outputs are not updated. They are not counted as drops.
- V0_AS_OFF: if status is 9n and d2 = 0, then msg_status = 8n.
- drop_cnt: saturates at 255; it is cleared only by reset.
- Simultaneity: strobes are at least 1 cycle apart, guaranteed upstream. msg_valid and rt_valid never coincide, because each follows its own strobe.

Test Plan:
- Note On: 0x93, 0x3C, 0x64 -> one msg_valid with status 0x93, d1 0x3C, d2 0x64, exactly 1 cycle after the third strobe.
- Running status: 0x90, 0x40, 0x7F, 0x41, 0x00 -> two messages: (0x90, 0x40, 0x7F), then (0x80, 0x41, 0x00) with V0_AS_OFF = 1.
- Realtime interleave: 0xB0, 0x07, 0xF8, 0x64 -> rt_valid with rt_byte 0xF8 after the 0xF8 strobe; then a message (0xB0, 0x07, 0x64); no extra msg_valid.
- Program Change / SysEx / orphans:
  - 0xC5, 0x0A -> (0xC5, 0x0A, 0x00).
  - Then 0xF0, 0x01, 0x02, 0xF7, 0x05 -> no messages; drop_cnt = 1, because running status was cleared by F0.
- Filter: OMNI = 0, CHANNEL = 2; 0x91, 0x30, 0x40 then 0x92, 0x30, 0x40 -> only (0x92, 0x30, 0x40) is emitted.
- Reset mid-message: 0x90, 0x40, assert sys_rst 1 cycle, then 0x50 -> no msg_valid; drop_cnt = 1; all outputs 0 after reset.
